// File: rtl/mx_pkg.sv
// mx_pkg: shared framing constants and transmitter state type for the mx serial link.
package mx_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_CHK,
        S_EOF
    } mx_xmit_state_t;
    localparam logic [7:0] MX_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] MX_SFD = 8'hD0;
    localparam int MX_EOF_BITS = 2;
endpackage

// File: rtl/mx_xmit_if.sv
// mx_xmit_if: byte valid/ready handshake into the Manchester transmitter.
interface mx_xmit_if;
    logic [7:0] data;
    logic valid;
    logic rdy;
    modport master (output data, output valid, input rdy);
    modport slave (input data, input valid, output rdy);
endinterface

// File: rtl/mx_tick_gen.sv
// mx_tick_gen: free-running divider producing a one-cycle tick every DIVISOR clocks.
module mx_tick_gen #(
    parameter int DIVISOR = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIVISOR - 1);
    always_ff @(posedge clk)
        cnt <= (rst || restart || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/mx_xmit.sv
// mx_xmit: Manchester frame transmitter (preamble, SFD, data LSB first, EOF idle).
// Optional trailing XOR checksum byte enabled by defining MX_XMIT_CHKSUM_EN.
module mx_xmit import mx_pkg::*; #(
    parameter int CLKFREQ = 100_000_000,
    parameter int BIT_RATE = 50_000,
    parameter int PREAMBLE_BYTES = 2
) (
    input  logic     clk,
    input  logic     rst,
    mx_xmit_if.slave bus,
    output logic     txen,
    output logic     txd
);
    localparam int HB = CLKFREQ / (2 * BIT_RATE);
    localparam int PW = PREAMBLE_BYTES > 1 ? $clog2(PREAMBLE_BYTES) : 1;

    if (CLKFREQ % (2 * BIT_RATE) != 0) begin : g_bad_div
        $error("mx_xmit: CLKFREQ must be divisible by 2*BIT_RATE");
    end

    mx_xmit_state_t state;
    logic [7:0] hold, sr;
    logic [2:0] bcnt;
    logic [PW-1:0] pcnt;
    logic ph, tick, start;
`ifdef MX_XMIT_CHKSUM_EN
    logic [7:0] chk;
`endif

    // bus.rdy doubles as the hold-empty flag
    assign start = state == S_IDLE && !bus.rdy;

    mx_tick_gen #(.DIVISOR(HB)) u_tick (
        .clk(clk),
        .rst(rst),
        .restart(start),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            hold <= '0;
            sr <= '0;
            bcnt <= '0;
            pcnt <= '0;
            ph <= 1'b0;
            bus.rdy <= 1'b1;
            txen <= 1'b0;
            txd <= 1'b1;
`ifdef MX_XMIT_CHKSUM_EN
            chk <= '0;
`endif
        end else begin
            if (bus.valid && bus.rdy) begin
                hold <= bus.data;
                bus.rdy <= 1'b0;
            end
            if (start) begin
                state <= S_PREAMBLE;
                txen <= 1'b1;
                sr <= MX_PREAMBLE_BYTE;
                txd <= MX_PREAMBLE_BYTE[0];
                bcnt <= '0;
                pcnt <= '0;
                ph <= 1'b0;
`ifdef MX_XMIT_CHKSUM_EN
                chk <= '0;
`endif
            end else if (state != S_IDLE && tick) begin
                ph <= ~ph;
                if (!ph) begin
                    txd <= (state == S_EOF) || !sr[0];
                end else if (state == S_EOF) begin
                    bcnt <= bcnt + 3'd1;
                    if (bcnt == 3'(MX_EOF_BITS - 1)) begin
                        state <= S_IDLE;
                        txen <= 1'b0;
                    end
                end else if (bcnt != 3'd7) begin
                    bcnt <= bcnt + 3'd1;
                    sr <= sr >> 1;
                    txd <= sr[1];
                end else begin
                    // byte boundary: next byte starts on this same edge
                    bcnt <= '0;
                    if (state == S_PREAMBLE && pcnt != PW'(PREAMBLE_BYTES - 1)) begin
                        pcnt <= pcnt + PW'(1);
                        sr <= MX_PREAMBLE_BYTE;
                        txd <= MX_PREAMBLE_BYTE[0];
                    end else if (state == S_PREAMBLE) begin
                        state <= S_SFD;
                        sr <= MX_SFD;
                        txd <= MX_SFD[0];
                    end else if ((state == S_SFD || state == S_DATA) && !bus.rdy) begin
                        state <= S_DATA;
                        sr <= hold;
                        txd <= hold[0];
                        bus.rdy <= 1'b1;
`ifdef MX_XMIT_CHKSUM_EN
                        chk <= chk ^ hold;
                    end else if (state == S_SFD || state == S_DATA) begin
                        state <= S_CHK;
                        sr <= chk;
                        txd <= chk[0];
`endif
                    end else begin
                        state <= S_EOF;
                        txd <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/mx_xmit.md
# mx_xmit

Manchester transmitter that pairs with `mx_rcvr` on the serial link. It accepts bytes over a valid/ready handshake and frames them as preamble, SFD, data bytes (LSB first) and an end-of-frame idle. The output `txd` drives the line that `mx_rcvr.rxd` samples. `txen` marks frame activity for the line driver and the LEDs.

## Interface
- `CLKFREQ`, default 100_000_000: system clock frequency in Hz.
- `BIT_RATE`, default 50_000: line bit rate in bits/s.
- `PREAMBLE_BYTES`, default 2: number of 0x55 preamble bytes (2 bytes = 16 alternating bits).
- `clk` input, 1: system clock. One clock domain only.
- `rst` input, 1: reset, synchronous, active-high.
- `data` input, 8: byte to send.
- `valid` input, 1: `data` is valid. A transfer happens on a posedge where `valid && rdy`.
- `rdy` output, 1: the holding register is empty.
- `txen` output, 1: a frame is in progress (preamble through EOF).
- `txd` output, 1: Manchester line. Idle level is 1.

## Operation
- Encoding:
  - 1 is sent as high for the first half-bit, then low for the second.
  - 0 is sent as low for the first half-bit, then high for the second.
  - Bits go out LSB first.
- Frame layout:
  - PREAMBLE: `PREAMBLE_BYTES` × 0x55, giving the line sequence 1,0,1,0,…
  - SFD: 0xD0, giving the line sequence 0,0,0,0,1,0,1,1.
  - DATA: one or more data bytes.
  - Optional checksum byte.
  - EOF: `txd`=1 held for 2 bit periods.
- Buffering: one holding register (`hold`) plus an 8-bit shift register.
  - `rdy` = hold empty.
  - A transfer fills hold; `rdy` falls on the next cycle.
- FSM states: IDLE, PREAMBLE, SFD, DATA, CHK (macro only), EOF.
- IDLE → PREAMBLE on the cycle after hold becomes full. `txen` rises on that same cycle.
- PREAMBLE → SFD after `PREAMBLE_BYTES`×8 bits. SFD → DATA after 8 bits.
- On entering DATA, and at every DATA byte boundary:
  - If hold is full: hold moves into the shift register, hold empties, and `rdy` rises on the next cycle.
  - If hold is empty: go to CHK (macro on) or EOF (macro off).
- A byte loaded into hold during PREAMBLE or SFD waits for the DATA entry.
- EOF: `txd`=1 for 2 bit periods, then IDLE with `txen`=0.
- A `valid` during EOF is accepted, since hold is empty. The new frame starts on the cycle after IDLE is reached. There is no back-to-back frame merge.
- `valid` while `rdy`=0 is ignored. `data` is sampled only on a transfer.
- Reset (including mid-frame) takes effect at the next posedge:
  - State goes to IDLE; hold and shift register are cleared; counters are zeroed.
  - Outputs: `txd`=1, `txen`=0, `rdy`=1.
  - The partial frame is abandoned. The receiver sees it as an error.

## Timing
- Half-bit period is `HB = CLKFREQ/(2*BIT_RATE)` clocks; with the defaults this is 1000. The bit period is 2·HB = 2000.
- `CLKFREQ` must be divisible by 2·`BIT_RATE`; an elaboration-time `$error` fires otherwise.
- Half-bit counter width is `$clog2(HB)`.
- All outputs are registered.
- The first half of the first preamble bit starts the cycle after the frame start. `txd` changes only on half-bit tick boundaries.
- Byte boundary occurs on the last clock of the 8th bit. Hold→shift and the state decision happen on that cycle, with no gap between bytes.
- `rdy` returns high at most 1 cycle after hold is consumed.
- Frame length:
  - Macro off: (8·`PREAMBLE_BYTES` + 8 + 8·N + 2) bit periods.
  - Macro on: 8 more bit periods.

## Configuration
- `MX_XMIT_CHKSUM_EN` defined:
  - A CHK state sends one byte after the last data byte.
  - The byte is the XOR of all data bytes in the frame; an empty XOR is never possible because DATA always holds at least one byte.
  - The accumulator clears on frame start.
- Undefined: DATA goes directly to EOF, and no accumulator logic is present.

## Structure
- `mx_pkg` holds:
  - the state enum `mx_xmit_state_t`;
  - `MX_PREAMBLE_BYTE` = 8'h55 and `MX_SFD` = 8'hD0;
  - `MX_EOF_BITS` = 2.
- `mx_rcvr` also imports `mx_pkg` for SFD and preamble.
- Sub-module `mx_tick_gen #(.DIVISOR(HB))` is a free-running half-bit tick.
  - It is reset synchronously, and also restarted when IDLE exits, so the first half-bit is exactly HB clocks.
- The top level holds the FSM, bit and byte counters, hold and shift registers, and the optional checksum.

## Test plan
- Reset, then `valid`=0 for 10 bit periods → `txd`=1, `txen`=0, `rdy`=1 throughout.
- Single byte 0xA5, decoded by a bench Manchester sampler at half-bit centres:
  - Expect 16 bits 1,0,…, then SFD 0,0,0,0,1,0,1,1, then bits 1,0,1,0,0,1,0,1, then `txd`=1 for 4000 clocks.
  - `txen` then falls.
  - Frame is 34 bit periods, or 42 with `MX_XMIT_CHKSUM_EN`, which appends 0xA5.
- Bytes 0x12, 0x34, 0x56 driven on every `rdy` rising edge → contiguous data with no idle half-bits between bytes.
  - `rdy` is low from each transfer until the next hold→shift.
  - With the macro, the checksum byte is 0x70.
- `valid` held high with changing `data` while `rdy`=0 → only bytes sampled at transfers appear on the line.
- Reset asserted mid-byte during DATA → next cycle `txd`=1, `txen`=0, `rdy`=1. A new 0x3C frame afterwards is correct.
- Loopback into `mx_rcvr #(.BIT_RATE(50000))` with 3 random bytes:
  - Receiver `valid` pulses 3 times with matching `data`.
  - `cardet` falls after EOF, and `error` stays 0.
